// File: rtl/graph_point_fifo.sv
// graph_point_fifo
//   Assembles signed coordinates arriving one per beat into DIM-wide points,
//   drops malformed frames, and buffers complete points in a DEPTH-entry
//   first-word-fall-through FIFO with a valid/ready output handshake.
//
//   Optional feature macro: GRAPH_BBOX_EN builds a running per-dimension
//   signed bounding box over every point pushed into the FIFO. Without it,
//   bbox_clr is ignored and the bbox outputs are tied to zero.
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   in_valid      coordinate beat valid
//   in_ready      beat can be accepted (low only while the FIFO is full)
//   in_coord      signed coordinate, W bits
//   in_last       last coordinate of a point
//   out_valid     head point available
//   out_ready     consumer takes the head point
//   out_point     head point, dimension d at [d*W +: W]
//   count         points held in the FIFO
//   err_frame     one-cycle pulse after a short or long frame is detected
//   bbox_clr      clear the bounding box
//   bbox_min/max  per-dimension signed minimum / maximum
//   bbox_valid    bounding box holds at least one point
//
// Assembler states
//   state   | meaning
//   COLLECT | gathering lanes of the current point, idx = next lane
//   DISCARD | dropping the tail of an over-long frame until in_last
module graph_point_fifo #(
  parameter int W     = 16,
  parameter int DIM   = 2,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [W-1:0]                 in_coord,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DIM*W-1:0]             out_point,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         err_frame,
  input  logic                         bbox_clr,
  output logic [DIM*W-1:0]             bbox_min,
  output logic [DIM*W-1:0]             bbox_max,
  output logic                         bbox_valid
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int IDX_W = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM-1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic {COLLECT = 1'b0, DISCARD = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               accept, push, pop, lane_we, err_d, err_q;
  logic [W-1:0]       lane_q [DIM];
  logic [DIM*W-1:0]   push_point;
  logic [DIM*W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count_q;

  // Handshake flags come only from the registered count, so out_ready has
  // no combinational path to in_ready.
  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign count     = count_q;
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign err_frame = err_q;
  assign out_point = out_valid ? mem[rd_ptr] : '0;

  // Assembler: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Assembler: next state
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (accept) begin
      case (state_q)
        COLLECT: begin
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (!in_last) state_d = DISCARD;
          end else if (in_last) begin
            idx_d = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        DISCARD: begin
          if (in_last) begin
            state_d = COLLECT;
            idx_d   = '0;
          end
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  // Assembler: outputs
  always_comb begin
    push    = 1'b0;
    lane_we = 1'b0;
    err_d   = 1'b0;
    if (accept && state_q == COLLECT) begin
      if (idx_q == LAST_IDX) begin
        if (in_last) push = 1'b1;
        else         err_d = 1'b1;
      end else begin
        if (in_last) err_d = 1'b1;
        else         lane_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  always_ff @(posedge clk) begin
    for (int d = 0; d < DIM; d++) begin
      if (rst)                                   lane_q[d] <= '0;
      else if (lane_we && idx_q == IDX_W'(d))    lane_q[d] <= in_coord;
    end
  end

  // The final lane comes straight from the beat so the point is pushed on
  // the same edge that accepts in_last.
  always_comb begin
    push_point = '0;
    for (int d = 0; d < DIM; d++) begin
      push_point[d*W +: W] = (d == DIM-1) ? in_coord : lane_q[d];
    end
  end

  // FIFO storage; contents need no reset since out_point is masked by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_point;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef GRAPH_BBOX_EN
  logic [DIM*W-1:0] bmin_q, bmax_q;
  logic             bvalid_q;

  // A clear coinciding with a push restarts the box from that point.
  always_ff @(posedge clk) begin
    if (rst) begin
      bmin_q   <= '0;
      bmax_q   <= '0;
      bvalid_q <= 1'b0;
    end else if (push) begin
      for (int d = 0; d < DIM; d++) begin
        if (bbox_clr || !bvalid_q) begin
          bmin_q[d*W +: W] <= push_point[d*W +: W];
          bmax_q[d*W +: W] <= push_point[d*W +: W];
        end else begin
          if ($signed(push_point[d*W +: W]) < $signed(bmin_q[d*W +: W]))
            bmin_q[d*W +: W] <= push_point[d*W +: W];
          if ($signed(push_point[d*W +: W]) > $signed(bmax_q[d*W +: W]))
            bmax_q[d*W +: W] <= push_point[d*W +: W];
        end
      end
      bvalid_q <= 1'b1;
    end else if (bbox_clr) begin
      bmin_q   <= '0;
      bmax_q   <= '0;
      bvalid_q <= 1'b0;
    end
  end

  assign bbox_min   = bmin_q;
  assign bbox_max   = bmax_q;
  assign bbox_valid = bvalid_q;
`else
  logic unused_bbox_clr;
  assign unused_bbox_clr = bbox_clr;
  assign bbox_min   = '0;
  assign bbox_max   = '0;
  assign bbox_valid = 1'b0;
`endif

endmodule

// File: tb/tb_graph_point_fifo.sv
module tb_graph_point_fifo;
  localparam int W     = 16;
  localparam int DIM   = 3;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PW    = DIM*W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_last = 1'b0;
  logic             out_ready = 1'b0;
  logic             bbox_clr = 1'b0;
  logic [W-1:0]     in_coord = '0;
  logic             in_ready, out_valid, err_frame, bbox_valid;
  logic [PW-1:0]    out_point, bbox_min, bbox_max;
  logic [CNT_W-1:0] count;

  graph_point_fifo #(.W(W), .DIM(DIM), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_coord(in_coord), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_point(out_point),
    .count(count), .err_frame(err_frame),
    .bbox_clr(bbox_clr), .bbox_min(bbox_min), .bbox_max(bbox_max), .bbox_valid(bbox_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of finished points, a queue of gathered
  // coordinates for the frame in progress, and a discard flag.
  logic [PW-1:0] mq[$];
  logic [W-1:0]  part[$];
  bit            disc = 1'b0;
  bit            err_m = 1'b0;
  int            bmin[DIM];
  int            bmax[DIM];
  bit            bvalid = 1'b0;
  bit            m_acc, m_pop, m_push;
  logic [PW-1:0] m_np;
  int            m_c;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      part.delete();
      disc  = 1'b0;
      err_m = 1'b0;
      bvalid = 1'b0;
      for (int d = 0; d < DIM; d++) begin bmin[d] = 0; bmax[d] = 0; end
    end else begin
      m_acc  = in_valid && (mq.size() < DEPTH);
      m_pop  = out_ready && (mq.size() > 0);
      m_push = 1'b0;
      m_np   = '0;
      err_m  = 1'b0;
      if (m_acc) begin
        if (disc) begin
          if (in_last) disc = 1'b0;
        end else begin
          part.push_back(in_coord);
          if (in_last) begin
            if (part.size() == DIM) begin
              m_push = 1'b1;
              for (int d = 0; d < DIM; d++) m_np[d*W +: W] = part[d];
            end else begin
              err_m = 1'b1;
            end
            part.delete();
          end else if (part.size() == DIM) begin
            err_m = 1'b1;
            disc  = 1'b1;
            part.delete();
          end
        end
      end
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back(m_np);
      if (m_push) begin
        for (int d = 0; d < DIM; d++) begin
          m_c = int'($signed(m_np[d*W +: W]));
          if (bbox_clr || !bvalid) begin
            bmin[d] = m_c;
            bmax[d] = m_c;
          end else begin
            if (m_c < bmin[d]) bmin[d] = m_c;
            if (m_c > bmax[d]) bmax[d] = m_c;
          end
        end
        bvalid = 1'b1;
      end else if (bbox_clr) begin
        for (int d = 0; d < DIM; d++) begin bmin[d] = 0; bmax[d] = 0; end
        bvalid = 1'b0;
      end
    end
  end

  logic [PW-1:0] e_min, e_max, e_head;
  logic          e_bvalid;

  always @(negedge clk) begin
    if (started) begin
      e_head = (mq.size() > 0) ? mq[0] : '0;
`ifdef GRAPH_BBOX_EN
      for (int d = 0; d < DIM; d++) begin
        e_min[d*W +: W] = bmin[d][W-1:0];
        e_max[d*W +: W] = bmax[d][W-1:0];
      end
      e_bvalid = bvalid;
`else
      e_min = '0;
      e_max = '0;
      e_bvalid = 1'b0;
`endif
      chk("count",      64'(count),     64'(mq.size()));
      chk("in_ready",   64'(in_ready),  64'(mq.size() != DEPTH));
      chk("out_valid",  64'(out_valid), 64'(mq.size() != 0));
      chk("out_point",  64'(out_point), 64'(e_head));
      chk("err_frame",  64'(err_frame), 64'(err_m));
      chk("bbox_min",   64'(bbox_min),  64'(e_min));
      chk("bbox_max",   64'(bbox_max),  64'(e_max));
      chk("bbox_valid", 64'(bbox_valid), 64'(e_bvalid));
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int c, input bit last);
    bit acc;
    int n;
    in_valid = 1'b1;
    in_coord = W'(c);
    in_last  = last;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout actual=stalled required=accepted at %0t", $time);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic point(input int a, input int b, input int c);
    beat(a, 1'b0);
    beat(b, 1'b0);
    beat(c, 1'b1);
  endtask

  task automatic reset_literals(input string tag);
    chk({tag, "_count"},     64'(count),      64'd0);
    chk({tag, "_in_ready"},  64'(in_ready),   64'd1);
    chk({tag, "_out_valid"}, 64'(out_valid),  64'd0);
    chk({tag, "_out_point"}, 64'(out_point),  64'd0);
    chk({tag, "_err"},       64'(err_frame),  64'd0);
    chk({tag, "_bvalid"},    64'(bbox_valid), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished at %0t", $time);
    $fatal(1, "watchdog");
  end

  int  pos;
  int  ready_pct;
  int  r;

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    started = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    reset_literals("rst");
    sync();

    // basic point and latency
    out_ready = 1'b1;
    point(3, 4, 5);
    @(negedge clk);
    chk("lat_out_valid", 64'(out_valid), 64'd1);
    chk("lat_out_point", 64'(out_point), 64'h0005_0004_0003);
    @(negedge clk);
    chk("pop_count", 64'(count), 64'd0);
    sync();

    // short frame
    beat(1, 1'b0);
    beat(2, 1'b1);
    @(negedge clk);
    chk("short_err", 64'(err_frame), 64'd1);
    chk("short_count", 64'(count), 64'd0);
    @(negedge clk);
    chk("short_err_once", 64'(err_frame), 64'd0);
    sync();
    point(3, 4, 5);
    @(negedge clk);
    chk("short_then_ok", 64'(out_point), 64'h0005_0004_0003);
    sync();

    // long frame then discard
    beat(1, 1'b0);
    beat(2, 1'b0);
    beat(9, 1'b0);
    @(negedge clk);
    chk("long_err", 64'(err_frame), 64'd1);
    sync();
    beat(9, 1'b1);
    @(negedge clk);
    chk("discard_no_err", 64'(err_frame), 64'd0);
    chk("discard_count", 64'(count), 64'd0);
    sync();
    point(7, 8, 6);
    @(negedge clk);
    chk("long_then_ok", 64'(out_point), 64'h0006_0008_0007);
    sync();

    // fill, stall, ordered drain
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) point(10+i, 20+i, 30+i);
    @(negedge clk);
    chk("full_count", 64'(count), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    sync();
    fork
      beat(40, 1'b0);
      begin
        repeat (3) @(negedge clk);
        chk("full_stall", 64'(in_ready), 64'd0);
        @(posedge clk); #1; out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
      end
    join
    beat(41, 1'b0);
    beat(42, 1'b1);
    @(negedge clk);
    chk("refill_head", 64'(out_point), 64'h001f_0015_000b);
    chk("refill_count", 64'(count), 64'd4);
    sync();
    out_ready = 1'b1;
    repeat (6) sync();

    // bounding box
    bbox_clr = 1'b1;
    sync();
    bbox_clr = 1'b0;
    @(negedge clk);
    chk("bbox_clr_valid", 64'(bbox_valid), 64'd0);
    sync();
    point(3, -4, 0);
    point(8, 5, 1);
    point(-2, 6, 2);
    @(negedge clk);
`ifdef GRAPH_BBOX_EN
    chk("bbox_min_lit", 64'(bbox_min), 64'h0000_fffc_fffe);
    chk("bbox_max_lit", 64'(bbox_max), 64'h0002_0006_0008);
    chk("bbox_valid_lit", 64'(bbox_valid), 64'd1);
`else
    chk("bbox_min_tied", 64'(bbox_min), 64'd0);
    chk("bbox_max_tied", 64'(bbox_max), 64'd0);
`endif
    sync();
    beat(1, 1'b0);
    beat(1, 1'b0);
    bbox_clr = 1'b1;
    beat(1, 1'b1);
    bbox_clr = 1'b0;
    @(negedge clk);
`ifdef GRAPH_BBOX_EN
    chk("bbox_clrpush_min", 64'(bbox_min), 64'h0001_0001_0001);
    chk("bbox_clrpush_max", 64'(bbox_max), 64'h0001_0001_0001);
    chk("bbox_clrpush_valid", 64'(bbox_valid), 64'd1);
`else
    chk("bbox_valid_tied", 64'(bbox_valid), 64'd0);
`endif
    sync();
    repeat (4) sync();

    // reset mid-frame with points queued
    out_ready = 1'b0;
    point(1, 2, 3);
    point(4, 5, 6);
    beat(7, 1'b0);
    rst = 1'b1;
    sync();
    rst = 1'b0;
    @(negedge clk);
    reset_literals("midrst");
    sync();
    out_ready = 1'b1;
    point(21, 22, 23);
    @(negedge clk);
    chk("post_rst_point", 64'(out_point), 64'h0017_0016_0015);
    sync();

    // randomized traffic
    pos = 0;
    ready_pct = 50;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 256 == 0) begin
        r = $urandom_range(0, 2);
        ready_pct = (r == 0) ? 10 : (r == 1) ? 50 : 95;
      end
      rst       = ($urandom_range(0, 499) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_coord  = W'($urandom);
      in_last   = ($urandom_range(0, 15) == 0) ? (pos != DIM-1) : (pos == DIM-1);
      out_ready = ($urandom_range(0, 99) < ready_pct);
      bbox_clr  = ($urandom_range(0, 63) == 0);
      @(negedge clk);
      if (rst) pos = 0;
      else if (in_valid && in_ready) pos = (in_last || pos == DIM-1) ? 0 : pos + 1;
      sync();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    bbox_clr = 1'b0;
    out_ready = 1'b1;
    repeat (10) sync();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/graph_point_fifo.md
# graph_point_fifo

Synthesizable successor to the graphing point model: assembles signed coordinates, arriving one per beat, into DIM-dimensional points. Completed points are buffered in a DEPTH-entry first-word-fall-through FIFO and delivered in parallel with a valid/ready handshake. Malformed frames are detected and dropped. Optionally, the block tracks a running per-dimension bounding box of all points accepted into the FIFO. It sits between a coordinate source (sampler or test stimulus) and the plot/render stage.

## Interface
- W, 16, coordinate width in bits, signed two's complement (2..32)
- DIM, 2, coordinates per point (1..8)
- DEPTH, 4, FIFO depth in points, power of two, ≥2
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  coordinate beat valid
- in_ready  out  1  block can accept a beat
- in_coord  in  W  signed coordinate
- in_last  in  1  marks last coordinate of a point
- out_valid  out  1  head point available
- out_ready  in  1  consumer takes head point
- out_point  out  DIM*W  head point; dimension d at [d*W +: W]
- count  out  $clog2(DEPTH+1)  points held in FIFO
- err_frame  out  1  one-cycle pulse on framing error
- bbox_clr  in  1  clear bounding box (GRAPH_BBOX_EN only)
- bbox_min / bbox_max  out  DIM*W  per-dimension signed min/max (GRAPH_BBOX_EN only)
- bbox_valid  out  1  bounding box holds ≥1 point (GRAPH_BBOX_EN only)

## Operation
- A beat is accepted when in_valid && in_ready.
- The assembler holds a beat index idx (0..DIM-1) and has two states: COLLECT and DISCARD.
- COLLECT, accepted beat, idx<DIM-1, !in_last: store the coordinate into lane idx and increment idx.
- COLLECT, accepted beat, idx<DIM-1, in_last: this is a short frame. The partial point is dropped, err_frame pulses, and idx returns to 0.
- COLLECT, accepted beat, idx==DIM-1, in_last: the point is complete. It is pushed into the FIFO and idx returns to 0.
- COLLECT, accepted beat, idx==DIM-1, !in_last: this is a long frame. The point is dropped, err_frame pulses, and the state goes to DISCARD.
- DISCARD: accepted beats are dropped. The beat with in_last returns the state to COLLECT with idx=0. No further err_frame pulse is issued.
- DIM=1: every valid frame has in_last on each beat.
- in_ready is 0 only while count==DEPTH. It is 1 otherwise, including during partial collection and DISCARD.
- A full FIFO therefore stalls every beat, not just the final one. There is no combinational path from out_ready to in_ready.
- Pop occurs when out_valid && out_ready. out_valid = (count!=0). out_point always shows the head entry and holds it stable while out_valid && !out_ready.
- Simultaneous push and pop (possible only when count<DEPTH) leaves count unchanged.
- Points leave in arrival order. The pointers wrap modulo DEPTH.
- Reset mid-frame discards the partial point and all FIFO contents.

## Timing
- Reset values: in_ready=1, out_valid=0, out_point=0, count=0, err_frame=0, bbox_min=0, bbox_max=0, bbox_valid=0, state=COLLECT, idx=0.
- Latency: a final beat accepted at edge k gives out_valid=1 and the new point on out_point after edge k (visible in cycle k+1) when the FIFO was empty.
- err_frame is high for exactly the one cycle following the edge at which the offending beat was accepted.
- count, in_ready and out_valid are registered, or derived from registered count only.
- bbox outputs update on the edge after the push that changes them.

## Configuration
- GRAPH_BBOX_EN defined:
  - Bounding-box logic is built.
  - On each FIFO push, every lane d updates as min/max(signed) of the stored value and the pushed coordinate.
  - The first push after reset or bbox_clr loads both min and max from the point and sets bbox_valid=1.
  - bbox_clr alone zeroes min/max and clears bbox_valid.
  - bbox_clr in the same cycle as a push loads the box from that point, with bbox_valid=1.
  - Popping does not affect the box.
- GRAPH_BBOX_EN undefined:
  - bbox_clr is ignored.
  - bbox_min, bbox_max and bbox_valid are tied to 0.
  - No compare logic is built.

## Test plan
- W=16, DIM=2, DEPTH=4; beats (3),(4,last), out_ready=1 -> out_valid one cycle after the last beat; out_point lane0=3, lane1=4; count returns to 0 after the pop.
- DIM=3; beats 5,6,7(last) ×4 then a fifth point with out_ready=0 -> count=4, in_ready=0; the fifth point's first beat stalls until one pop; FIFO order is preserved.
- DIM=3; beats 1,2(last) -> err_frame pulses once and nothing is pushed; next beats 3,4,5(last) -> point (3,4,5) is delivered.
- DIM=2; beats 1,2,9,9(last) -> one err_frame pulse; DISCARD consumes the 9s; then (7,8 last) -> point (7,8) only.
- GRAPH_BBOX_EN, DIM=2; push (3,-4),(8,5),(-2,6) -> bbox_min=(-2,-4), bbox_max=(8,6); bbox_clr together with a push of (1,1) -> min=max=(1,1), bbox_valid=1.
- rst asserted after the first beat of a point with 2 points queued -> all outputs at reset values next cycle; the following full frame is delivered normally.
